// File: rtl/input_skew_feeder.sv
// Loads a ROW x K operand tile from a word-serial stream, then feeds it to the
// systolic array's west edge with row r delayed by r cycles.
module input_skew_feeder #(
  parameter int ROW   = 4,
  parameter int K     = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   hold,
  output logic [ROW*WIDTH-1:0]   west_out,
  output logic [ROW-1:0]         west_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int RW    = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int CW    = (K > 1) ? $clog2(K) : 1;
  localparam int STEPS = K + ROW - 1;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int OW    = SW + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [RW-1:0]     row_cnt;
  logic [CW-1:0]     col_cnt;
  logic [SW-1:0]     step;
  logic [WIDTH-1:0]  mem [ROW][K];

  logic fire;
  logic last_col;
  logic last_word;
  logic last_step;

  assign fire      = in_valid && (state == LOAD);
  assign last_col  = (col_cnt == CW'(K - 1));
  assign last_word = last_col && (row_cnt == RW'(ROW - 1));
  assign last_step = (step == SW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (fire && last_word) state_next = STREAM;
      STREAM:  if (!hold && last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
      step    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt <= '0;
            col_cnt <= '0;
          end
        end
        LOAD: begin
          if (fire) begin
            if (last_word) begin
              row_cnt <= '0;
              col_cnt <= '0;
              step    <= '0;
            end else if (last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + RW'(1);
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        STREAM: begin
          if (!hold) begin
            step <= last_step ? '0 : step + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand storage needs no reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (fire) begin
      mem[row_cnt][col_cnt] <= in_data;
    end
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == STREAM);
  assign done     = (state == DONE);

  // A borrow out of step - r means the lane has not started yet.
  for (genvar r = 0; r < ROW; r++) begin : g_lane
    logic [OW-1:0] offset;
    logic          lane_on;

    assign offset  = {1'b0, step} - OW'(r);
    assign lane_on = (state == STREAM) && !offset[SW] && (offset < OW'(K));

    assign west_valid[r]               = lane_on;
    assign west_out[r*WIDTH +: WIDTH]  = lane_on ? mem[r][offset[CW-1:0]] : '0;
  end

endmodule
